// File: rtl/attack_envelope.sv
// ============================================================================
// attack_envelope
// ----------------------------------------------------------------------------
// Note-onset amplitude ramp. The incoming signed sample stream is multiplied
// by a gain that climbs from 0/8 to 8/8 in eighths. The gain takes one step
// every (note_duration * STEP_SCALE) sample strobes and then holds at full
// scale. The block sits between the note player's sample source and the
// release-decay stage. Both stages share the same generate_next_sample
// strobe, so a note swells in on start and fades out on end.
//
// Parameters
//   STEP_SCALE : sample strobes per gain step, per unit of note_duration
//   CNT_W      : width of the step counter (must hold 63 * STEP_SCALE)
//
// Ports
//   clk                  in   system clock
//   reset                in   synchronous, active-high reset
//   note_duration [5:0]  in   note length code, latched on an accepted new_note
//   sample [15:0]        in   signed two's-complement input sample
//   new_note             in   one-cycle pulse, starts an attack
//   done_with_note       in   one-cycle pulse, note ended (back to IDLE)
//   generate_next_sample in   sample strobe, one output sample per strobe
//   final_sample [15:0]  out  signed scaled sample (registered, held between strobes)
//   final_sample_valid   out  one-cycle pulse, the cycle after a strobe
//   gain [3:0]           out  current gain in eighths (0..8)
//   attack_done          out  high while in SUSTAIN
//
// Build option
//   ATTACK_RETRIGGER_EN : when defined, a new_note during ATTACK restarts the
//                         ramp. When undefined, that new_note is ignored and
//                         the running ramp completes with its original
//                         duration.
// ============================================================================
module attack_envelope #(
    parameter int STEP_SCALE = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         note_duration,
    input  logic signed [15:0] sample,
    input  logic               new_note,
    input  logic               done_with_note,
    input  logic               generate_next_sample,
    output logic signed [15:0] final_sample,
    output logic               final_sample_valid,
    output logic [3:0]         gain,
    output logic               attack_done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ATTACK  = 2'd1;
    localparam logic [1:0] ST_SUSTAIN = 2'd2;

    localparam logic [3:0] GAIN_ZERO = 4'd0;
    localparam logic [3:0] GAIN_FULL = 4'd8;
    localparam logic [3:0] GAIN_LAST = 4'd7;

    // ------------------------------------------------------------------------
    // Scale a sample by gain/8. The gain is zero-extended into a 20-bit signed
    // product. The product is arithmetic-shifted right by three, which rounds
    // toward minus infinity, and then truncated to 16 bits. The worst case is
    // -32768 * 8, which still fits in 20 bits, and gain 8 reproduces the
    // sample exactly, so no saturation is required.
    // ------------------------------------------------------------------------
    function automatic logic signed [15:0] scale_sample(
        input logic signed [15:0] smp,
        input logic [3:0]         g
    );
        logic signed [19:0] smp_w;
        logic signed [19:0] g_w;
        logic signed [19:0] prod;
        logic signed [19:0] shifted;
        smp_w   = {{4{smp[15]}}, smp};
        g_w     = {16'd0, g};
        prod    = smp_w * g_w;
        shifted = prod >>> 3;
        return shifted[15:0];
    endfunction

    // ------------------------------------------------------------------------
    // Registers and next-state signals
    // ------------------------------------------------------------------------
    logic [1:0]         state_r;
    logic [1:0]         state_s;
    logic [3:0]         gain_r;
    logic [3:0]         gain_s;
    logic [CNT_W-1:0]   step_cnt_r;
    logic [CNT_W-1:0]   step_cnt_s;
    logic [5:0]         dur_r;
    logic [5:0]         dur_s;
    logic signed [15:0] final_sample_r;
    logic               valid_r;
    logic               attack_done_r;

    logic               accept_s;
    logic [3:0]         gain_eff_s;
    logic [CNT_W-1:0]   step_len_s;
    logic [CNT_W-1:0]   step_last_s;
    logic signed [15:0] scaled_s;

    // Decide whether a new_note pulse is honoured in the current state.
    always_comb begin
        accept_s = 1'b0;
`ifdef ATTACK_RETRIGGER_EN
        // Every state accepts a new note. During ATTACK this restarts the ramp.
        accept_s = new_note;
`else
        // The running ramp is never interrupted by another note-on.
        if (state_r != ST_ATTACK) begin
            accept_s = new_note;
        end else begin
            accept_s = 1'b0;
        end
`endif
    end

    // Compute the effective gain and step length and scale the current sample.
    always_comb begin
        // A note end or a fresh note mutes the sample taken this very cycle.
        // A step taken on a strobe only affects later strobes, because the
        // gain register is used here and not its next value.
        if (done_with_note || accept_s) begin
            gain_eff_s = GAIN_ZERO;
        end else begin
            gain_eff_s = gain_r;
        end
        step_len_s  = CNT_W'(dur_r) * CNT_W'(STEP_SCALE);
        step_last_s = step_len_s - {{(CNT_W-1){1'b0}}, 1'b1};
        scaled_s    = scale_sample(sample, gain_eff_s);
    end

    // Next-state logic for the envelope FSM, gain, step counter and latched duration.
    always_comb begin
        state_s    = state_r;
        gain_s     = gain_r;
        step_cnt_s = step_cnt_r;
        dur_s      = dur_r;

        if (accept_s) begin
            // An accepted new_note takes priority over done_with_note.
            // A strobe in this cycle does not advance the counter.
            dur_s      = note_duration;
            step_cnt_s = {CNT_W{1'b0}};
            if (note_duration == 6'd0) begin
                state_s = ST_SUSTAIN;
                gain_s  = GAIN_FULL;
            end else begin
                state_s = ST_ATTACK;
                gain_s  = GAIN_ZERO;
            end
        end else if (done_with_note) begin
            state_s    = ST_IDLE;
            gain_s     = GAIN_ZERO;
            step_cnt_s = {CNT_W{1'b0}};
        end else if (generate_next_sample) begin
            case (state_r)
                ST_ATTACK: begin
                    if (step_cnt_r == step_last_s) begin
                        step_cnt_s = {CNT_W{1'b0}};
                        gain_s     = gain_r + 4'd1;
                        // The eighth step reaches full scale and ends the attack.
                        if (gain_r == GAIN_LAST) begin
                            state_s = ST_SUSTAIN;
                        end else begin
                            state_s = ST_ATTACK;
                        end
                    end else begin
                        step_cnt_s = step_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_SUSTAIN: begin
                    state_s = ST_SUSTAIN;
                end
                default: begin
                    // An unreachable encoding parks the machine safely in IDLE.
                    state_s    = ST_IDLE;
                    gain_s     = GAIN_ZERO;
                    step_cnt_s = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Register the FSM, the gain, the counter and the latched duration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            gain_r     <= GAIN_ZERO;
            step_cnt_r <= {CNT_W{1'b0}};
            dur_r      <= 6'd0;
        end else begin
            state_r    <= state_s;
            gain_r     <= gain_s;
            step_cnt_r <= step_cnt_s;
            dur_r      <= dur_s;
        end
    end

    // Register the output sample, its valid pulse and the attack_done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            final_sample_r <= 16'sd0;
            valid_r        <= 1'b0;
            attack_done_r  <= 1'b0;
        end else begin
            valid_r       <= generate_next_sample;
            attack_done_r <= (state_s == ST_SUSTAIN);
            // The output holds its value between strobes.
            if (generate_next_sample) begin
                final_sample_r <= scaled_s;
            end else begin
                final_sample_r <= final_sample_r;
            end
        end
    end

    assign final_sample       = final_sample_r;
    assign final_sample_valid = valid_r;
    assign gain               = gain_r;
    assign attack_done        = attack_done_r;

endmodule
